cache_controller: RTL and testbench

- Main FSM directly upstream of cache_memory in the n-way set-associative cache.
- Accepts one CPU load/store at a time and splits the address into tag, index and word offset.
- Sequences cache_memory's enable handshakes through lookup, dirty write-back and refill, then retries the lookup to completion.
- Keeps saturating hit, miss and write-back counters for performance analysis.

---
 rtl/cache_controller.sv | 170 +++++++++++++++++
 tb/tb_cache_controller.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// cache_controller: main FSM in front of cache_memory. It accepts one CPU
// load/store at a time, drives the lookup / write-back / refill enables and
// retries the lookup after a refill. It also keeps saturating hit/miss/
// write-back counters.
//
// Handshake: a CPU request transfers on a rising edge where
// cpu_valid && cpu_ready. cpu_ready is high only in IDLE, so the CPU holds
// its request until then. cpu_done pulses for one cycle and cpu_rdata holds
// the load result until the next cpu_done. Main memory works the same way:
// mem_req stays high until a one-cycle mem_ack.
module cache_controller #(
    parameter int WORD_SIZE       = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_BLOCKS      = 64,
    parameter int NUM_WAYS        = 2,
    parameter int CNT_WIDTH       = 16,
    localparam int NUM_SETS       = NUM_BLOCKS / NUM_WAYS,
    localparam int INDEX_WIDTH    = $clog2(NUM_SETS),
    localparam int OFFSET_WIDTH   = $clog2(WORDS_PER_BLOCK),
    localparam int TAG_WIDTH      = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_valid,
    input  logic [31:0]             cpu_addr,
    input  logic                    cpu_req_type,
    input  logic [WORD_SIZE-1:0]    cpu_wdata,
    output logic                    cpu_ready,
    output logic                    cpu_done,
    output logic [WORD_SIZE-1:0]    cpu_rdata,
    output logic [TAG_WIDTH-1:0]    tag,
    output logic [INDEX_WIDTH-1:0]  index,
    output logic [OFFSET_WIDTH-1:0] blk_offset,
    output logic                    req_type,
    output logic [WORD_SIZE-1:0]    data_in,
    output logic                    read_en_cache,
    output logic                    write_en_cache,
    output logic                    read_en_mem,
    output logic                    write_en_mem,
    input  logic                    hit,
    input  logic                    dirty_bit,
    input  logic [WORD_SIZE-1:0]    data_out,
    output logic                    mem_req,
    output logic                    mem_we,
    input  logic                    mem_ack,
    output logic [CNT_WIDTH-1:0]    hit_count,
    output logic [CNT_WIDTH-1:0]    miss_count,
    output logic [CNT_WIDTH-1:0]    wb_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        COMPARE    = 2'd1,
        WRITE_BACK = 2'd2,
        ALLOCATE   = 2'd3
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [31:0]            addr_q;
    logic                   req_type_q;
    logic [WORD_SIZE-1:0]   wdata_q;
    // Set once a refill completes so the follow-up lookup is not counted.
    logic                   retry_q;

    logic accept;
    logic cmp_hit;
    logic cmp_miss;

    assign accept   = (state == IDLE) && cpu_valid;
    assign cmp_hit  = (state == COMPARE) && hit;
    assign cmp_miss = (state == COMPARE) && !hit;

    // Cache-side address/data always come from the latched request.
    assign tag        = addr_q[31 -: TAG_WIDTH];
    assign index      = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
    assign blk_offset = addr_q[OFFSET_WIDTH-1:0];
    assign req_type   = req_type_q;
    assign data_in    = wdata_q;
    assign cpu_ready  = (state == IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic; a miss on the retry lookup simply re-enters the miss path.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (cpu_valid) next_state = COMPARE;
            COMPARE: begin
                if (hit)            next_state = IDLE;
                else if (dirty_bit) next_state = WRITE_BACK;
                else                next_state = ALLOCATE;
            end
            WRITE_BACK: if (mem_ack) next_state = ALLOCATE;
            ALLOCATE:   if (mem_ack) next_state = COMPARE;
            default:    next_state = IDLE;
        endcase
    end

    // Output decode: Moore enables, except the refill write qualified by mem_ack.
    always_comb begin
        read_en_cache  = 1'b0;
        write_en_cache = 1'b0;
        read_en_mem    = 1'b0;
        write_en_mem   = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        case (state)
            COMPARE: begin
                read_en_cache  = !req_type_q;
                write_en_cache = req_type_q;
            end
            WRITE_BACK: begin
                read_en_cache = 1'b1;
                write_en_mem  = 1'b1;
                mem_req       = 1'b1;
                mem_we        = 1'b1;
            end
            ALLOCATE: begin
                read_en_mem    = 1'b1;
                mem_req        = 1'b1;
                write_en_cache = mem_ack;
            end
            default: ;
        endcase
    end

    // Request latch, retry flag, completion pulse and load data.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            req_type_q <= 1'b0;
            wdata_q    <= '0;
            retry_q    <= 1'b0;
            cpu_done   <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            cpu_done <= cmp_hit;
            if (accept) begin
                addr_q     <= cpu_addr;
                req_type_q <= cpu_req_type;
                wdata_q    <= cpu_wdata;
                retry_q    <= 1'b0;
            end
            if ((state == ALLOCATE) && mem_ack) retry_q <= 1'b1;
            if (cmp_hit && !req_type_q) cpu_rdata <= data_out;
        end
    end

    // Saturating performance counters; retry lookups count as neither hit nor miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (cmp_hit && !retry_q && (hit_count != '1))
                hit_count <= hit_count + CNT_WIDTH'(1);
            if (cmp_miss && !retry_q && (miss_count != '1))
                miss_count <= miss_count + CNT_WIDTH'(1);
            if ((state == WRITE_BACK) && mem_ack && (wb_count != '1))
                wb_count <= wb_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a small 2-way cache_memory model
// and a fixed-latency main-memory responder. A second instance with 2-bit
// counters exercises saturation.
module tb_cache_controller;

  localparam int TW = 25;
  localparam int IW = 5;
  localparam int OW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic          cpu_valid = 1'b0;
  logic [31:0]   cpu_addr = '0;
  logic          cpu_req_type = 1'b0;
  logic [31:0]   cpu_wdata = '0;
  logic          cpu_ready, cpu_done;
  logic [31:0]   cpu_rdata;
  logic [TW-1:0] tag;
  logic [IW-1:0] index;
  logic [OW-1:0] blk_offset;
  logic          req_type;
  logic [31:0]   data_in;
  logic          read_en_cache, write_en_cache, read_en_mem, write_en_mem;
  logic          hit, dirty_bit;
  logic [31:0]   data_out;
  logic          mem_req, mem_we;
  logic          mem_ack = 1'b0;
  logic [15:0]   hit_count, miss_count, wb_count;

  cache_controller dut (
    .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_addr(cpu_addr),
    .cpu_req_type(cpu_req_type), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .tag(tag), .index(index),
    .blk_offset(blk_offset), .req_type(req_type), .data_in(data_in),
    .read_en_cache(read_en_cache), .write_en_cache(write_en_cache),
    .read_en_mem(read_en_mem), .write_en_mem(write_en_mem), .hit(hit),
    .dirty_bit(dirty_bit), .data_out(data_out), .mem_req(mem_req),
    .mem_we(mem_we), .mem_ack(mem_ack), .hit_count(hit_count),
    .miss_count(miss_count), .wb_count(wb_count)
  );

  // ---------------- saturation DUT (always hits) ----------------
  logic          s_valid = 1'b0;
  logic          s_ready, s_done;
  logic [31:0]   s_rdata, s_data_in;
  logic [TW-1:0] s_tag;
  logic [IW-1:0] s_index;
  logic [OW-1:0] s_off;
  logic          s_req_type, s_rec, s_wec, s_rem, s_wem, s_mem_req, s_mem_we;
  logic [1:0]    s_hit_count, s_miss_count, s_wb_count;

  cache_controller #(.CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .cpu_valid(s_valid), .cpu_addr(32'h0000_0010),
    .cpu_req_type(1'b0), .cpu_wdata(32'h0), .cpu_ready(s_ready),
    .cpu_done(s_done), .cpu_rdata(s_rdata), .tag(s_tag), .index(s_index),
    .blk_offset(s_off), .req_type(s_req_type), .data_in(s_data_in),
    .read_en_cache(s_rec), .write_en_cache(s_wec), .read_en_mem(s_rem),
    .write_en_mem(s_wem), .hit(1'b1), .dirty_bit(1'b0),
    .data_out(32'h1234_5678), .mem_req(s_mem_req), .mem_we(s_mem_we),
    .mem_ack(1'b0), .hit_count(s_hit_count), .miss_count(s_miss_count),
    .wb_count(s_wb_count)
  );

  // ---------------- cache_memory model ----------------
  logic          m_v   [2][32];
  logic          m_d   [2][32];
  logic [TW-1:0] m_tag [2][32];
  logic [127:0]  m_dat [2][32];
  logic          m_lru [32];       // way to evict next
  logic [127:0]  mem_line = '0;    // line returned by a refill
  logic [127:0]  wb_line = '0;     // line captured on write-back ack

  logic h0, h1, hw, vw;
  assign h0 = m_v[0][index] && (m_tag[0][index] == tag);
  assign h1 = m_v[1][index] && (m_tag[1][index] == tag);
  assign hw = h1;
  assign vw = !m_v[0][index] ? 1'b0 : (!m_v[1][index] ? 1'b1 : m_lru[index]);
  assign hit = h0 | h1;
  assign dirty_bit = m_v[vw][index] && m_d[vw][index];
  assign data_out = m_dat[hw][index][int'(blk_offset)*32 +: 32];

  always @(posedge clk) begin
    if (write_en_cache && read_en_mem) begin
      m_v[vw][index]   <= 1'b1;
      m_d[vw][index]   <= 1'b0;
      m_tag[vw][index] <= tag;
      m_dat[vw][index] <= mem_line;
      m_lru[index]     <= !vw;
    end else if (write_en_cache && hit) begin
      m_dat[hw][index][int'(blk_offset)*32 +: 32] <= data_in;
      m_d[hw][index] <= 1'b1;
      m_lru[index]   <= !hw;
    end else if (read_en_cache && hit && !write_en_mem) begin
      m_lru[index] <= !hw;
    end
    if (write_en_mem && mem_ack) wb_line <= m_dat[vw][index];
  end

  // ---------------- main-memory responder ----------------
  int mem_lat = 3;
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (rst) cnt = 0;
      else if (mem_req) begin
        cnt++;
        if (cnt >= mem_lat) begin
          mem_ack = 1'b1;
          cnt = 0;
        end
      end else cnt = 0;
    end
  end

  // ---------------- bus monitor ----------------
  int mem_req_n = 0;
  int wem_n = 0;
  int conflict_n = 0;
  always @(negedge clk) begin
    if (mem_req) mem_req_n++;
    if (write_en_mem) wem_n++;
    if (write_en_mem && read_en_mem) conflict_n++;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [TW-1:0] t, input logic [IW-1:0] i,
                                     input logic [OW-1:0] o);
    return {t, i, o};
  endfunction

  // ---------------- driver ----------------
  task automatic do_req(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input logic poke, output int lat);
    int n;
    n = 0;
    while (!cpu_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    cpu_addr = addr; cpu_req_type = wr; cpu_wdata = wd; cpu_valid = 1'b1;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    n = 1;
    while (!cpu_done && n < 200) begin
      if (poke && n == 3) begin
        check("busy_ready_low", cpu_ready, 1'b0);
        cpu_addr = 32'hFFFF_FFF0; cpu_req_type = 1'b1; cpu_valid = 1'b1;
      end
      @(posedge clk); #1;
      cpu_valid = 1'b0;
      n++;
    end
    check("done_seen", cpu_done, 1'b1);
    lat = n;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, base_req, base_wem, n, dones;

    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 32; s++) begin
        m_v[w][s] <= 1'b0; m_d[w][s] <= 1'b0; m_tag[w][s] <= '0; m_dat[w][s] <= '0;
      end
    for (int s = 0; s < 32; s++) m_lru[s] <= 1'b0;
    @(posedge clk);
    m_v[0][0] <= 1'b1; m_tag[0][0] <= 25'h1ABCDE;
    m_dat[0][0] <= 128'hDEADBEEF_55667788_11223344_AABBCCDD;
    m_v[0][1] <= 1'b1; m_d[0][1] <= 1'b1; m_tag[0][1] <= 25'h2AAAA;
    m_dat[0][1] <= 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
    m_v[1][1] <= 1'b1; m_tag[1][1] <= 25'h2BBBB;
    m_dat[1][1] <= 128'h0BBB0003_0BBB0002_0BBB0001_0BBB0000;
    m_v[0][2] <= 1'b1; m_d[0][2] <= 1'b1; m_tag[0][2] <= 25'h100;
    m_v[1][2] <= 1'b1; m_d[1][2] <= 1'b1; m_tag[1][2] <= 25'h101;
    @(posedge clk); #1;
    rst = 1'b0;

    // reset state
    check("rst_ready", cpu_ready, 1'b1);
    check("rst_done", cpu_done, 1'b0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_counts", {hit_count, miss_count, wb_count}, 48'h0);
    check("rst_enables", {read_en_cache, write_en_cache, read_en_mem, write_en_mem, mem_req, mem_we}, 6'h0);

    // read hit
    base_req = mem_req_n;
    do_req(mk(25'h1ABCDE, 5'd0, 2'd2), 1'b0, 32'h0, 1'b0, lat);
    check("rhit_lat", lat, 2);
    check("rhit_rdata", cpu_rdata, 32'h55667788);
    check("rhit_hits", hit_count, 16'd1);
    check("rhit_no_mem", mem_req_n - base_req, 0);

    // write hit
    do_req(mk(25'h1ABCDE, 5'd0, 2'd2), 1'b1, 32'h11112222, 1'b0, lat);
    check("whit_lat", lat, 2);
    check("whit_line", m_dat[0][0], 128'hDEADBEEF_11112222_11223344_AABBCCDD);
    check("whit_hits", hit_count, 16'd2);
    check("whit_no_mem", mem_req_n - base_req, 0);
    check("whit_rdata_held", cpu_rdata, 32'h55667788);

    // clean write miss
    mem_lat = 3;
    mem_line = 128'hCAFEBABE_FEEDFACE_DEADBEAF_87654321;
    base_wem = wem_n;
    do_req(mk(25'h12345, 5'd0, 2'd1), 1'b1, 32'h33334444, 1'b0, lat);
    check("cmiss_lat", lat, 6);
    check("cmiss_no_wb", wem_n - base_wem, 0);
    check("cmiss_line", m_dat[1][0], 128'hCAFEBABE_FEEDFACE_33334444_87654321);
    check("cmiss_tag", m_tag[1][0], 25'h12345);
    check("cmiss_miss", miss_count, 16'd1);
    check("cmiss_hits", hit_count, 16'd2);

    // dirty miss: read way1 so dirty way0 becomes the victim
    do_req(mk(25'h2BBBB, 5'd1, 2'd3), 1'b0, 32'h0, 1'b0, lat);
    check("dset_rdata", cpu_rdata, 32'h0BBB0003);
    check("dset_hits", hit_count, 16'd3);
    mem_line = 128'h11111111_22222222_33333333_44444444;
    do_req(mk(25'h2CCCC, 5'd1, 2'd0), 1'b1, 32'h5A5A5A5A, 1'b0, lat);
    check("dmiss_lat", lat, 9);
    check("dmiss_wb_line", wb_line, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
    check("dmiss_line", m_dat[0][1], 128'h11111111_22222222_33333333_5A5A5A5A);
    check("dmiss_wb_cnt", wb_count, 16'd1);
    check("dmiss_miss", miss_count, 16'd2);
    check("dmiss_hits", hit_count, 16'd3);

    // clean read miss with a request poked while busy
    mem_line = 128'h99990000_88881111_77772222_66663333;
    do_req(mk(25'h777, 5'd3, 2'd3), 1'b0, 32'h0, 1'b1, lat);
    check("busy_lat", lat, 6);
    check("busy_rdata", cpu_rdata, 32'h99990000);
    check("busy_tag_kept", tag, 25'h777);
    check("busy_type_kept", req_type, 1'b0);
    check("busy_miss", miss_count, 16'd3);
    check("busy_hits", hit_count, 16'd3);

    // reset during WRITE_BACK
    mem_lat = 10;
    cpu_addr = mk(25'h102, 5'd2, 2'd0); cpu_req_type = 1'b0; cpu_valid = 1'b1;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    n = 0;
    while (!mem_we && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("rwb_in_wb", {mem_we, write_en_mem}, 2'b11);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rwb_ready", cpu_ready, 1'b1);
    check("rwb_enables", {read_en_cache, write_en_cache, read_en_mem, write_en_mem, mem_req, mem_we}, 6'h0);
    check("rwb_counts", {hit_count, miss_count, wb_count}, 48'h0);
    check("rwb_rdata", cpu_rdata, 32'h0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (cpu_done) dones++;
      @(posedge clk); #1;
    end
    check("rwb_no_done", dones, 0);
    check("rwb_idle_stays", cpu_ready, 1'b1);

    // saturation on the 2-bit instance
    s_valid = 1'b1;
    dones = 0;
    n = 0;
    while (dones < 5 && n < 60) begin
      @(posedge clk); #1; n++;
      if (s_done) dones++;
      if (dones == 3 && s_done) check("sat_at3", s_hit_count, 2'd3);
    end
    s_valid = 1'b0;
    check("sat_dones", dones, 5);
    check("sat_hits", s_hit_count, 2'd3);
    check("sat_miss", s_miss_count, 2'd0);

    check("no_rd_wr_mem_overlap", conflict_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
